fp_normalize: RTL
=================

FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL have parameters: MANT_W default 53 (mantissa width incl. hidden bit); EXP_W default 11 (exponent width).
REQ-002 SHALL have ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  FSM advances only when high.
- start  input  1  one-cycle strobe: adder result valid.
- carry  input  1  adder carry-out (bit MANT_W).
- mant  input  53  adder magnitude; bit 52 is hidden bit.
- sign  input  1  result sign from adder.
- exp  input  11  biased common exponent of operands.
- result  output  64  packed IEEE-754 double.
- done  output  1  one-cycle pulse: result valid.
- busy  output  1  high in every state except IDLE.
- overflow  output  1  result became infinity; valid with done.
- zero  output  1  result magnitude is zero; valid with done.

Function
REQ-003 SHALL implement FSM states IDLE, CHECK, SHIFT, PACK; all transitions occur only on clk edges with en=1; en=0 freezes all state and registers (done still falls after one cycle).
REQ-004 IDLE: on start=1, SHALL capture carry/mant/sign/exp into internal registers and go to CHECK; start is ignored in every other state.
REQ-005 CHECK, priority order:
- exp=2047: pass through unchanged, go to PACK.
- carry=1: mant <= {1,mant[52:1]} (truncate, no rounding); exp <= exp+1; if new exp=2047, set mant=0 and flag overflow; go to PACK.
- mant=0: exp <= 0; flag zero; go to PACK.
- mant[52]=1 or exp=0: go to PACK.
- otherwise: go to SHIFT.
REQ-006 SHIFT: each edge SHALL apply mant <= mant<<1 and exp <= exp-1.
- After the shift, go to PACK if the new mant[52]=1 or the new exp=1; otherwise stay in SHIFT.
- Exp is never decremented below 1.
REQ-007 PACK: if mant[52]=0 and exp=1, SHALL store exponent 0 (denormal).
- result <= {sign, exp, mant[51:0]}.
- done <= 1 for exactly one cycle; overflow and zero are updated together with result.
- Go to IDLE.
REQ-008 Latency: with start sampled at edge 0 and N left shifts, done SHALL be high in the cycle after edge 2+N (en held high).
- N is at most 52.
REQ-009 result, overflow and zero SHALL hold their values until the next done.
REQ-010 Sign SHALL pass through unmodified in all cases, including zero (i.e. -0 is allowed).
REQ-011 A start arriving in the same cycle as done (state PACK) SHALL be ignored; the next start is accepted from IDLE.

Reset
REQ-012 rst=1 SHALL force IDLE, clear all internal registers, and drive result=0, done=0, busy=0, overflow=0, zero=0; it overrides en and start.
REQ-013 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts is processed normally.

Structure
REQ-014 Shared package fp_pkg SHALL hold EXP_W, MANT_W, BIAS=1023, EXP_MAX=2047 and the state encoding (IDLE, CHECK, SHIFT, PACK).
REQ-015 One sub-module is natural: fp_pack, a combinational packer of {sign, exp, mant} into the 64-bit field including the denormal exponent rule; everything else is flat.

Verification
REQ-016 The bench SHALL cover:
- mant=53'h10000000000000, exp=1023, sign=0, carry=0 -> result=64'h3FF0000000000000, done after edge 2, zero=0, overflow=0.
- mant=0, carry=1, exp=1023, sign=0 -> result=64'h4000000000000000 (1.0+1.0).
- mant=53'h08000000000000, exp=1023, sign=1, carry=0 -> one shift, result=64'hBFE0000000000000, done after edge 3.
- mant=0, carry=0, exp=1023, sign=0 -> result=0, zero=1; repeat with exp=2046, carry=1 -> result=64'h7FF0000000000000, overflow=1.
- mant=53'h1, exp=3, sign=0 -> two shifts, denormal, result=64'h0000000000000004.
- mant=53'h1, exp=1023, rst pulsed during SHIFT -> no done, all outputs 0; start with en toggled low for 3 cycles -> latency grows by exactly 3.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the FP normalizer.
// Widths default to IEEE-754 double precision.
package fp_pkg;

    localparam int MANT_W  = 53;
    localparam int EXP_W   = 11;
    localparam int BIAS    = 1023;
    localparam int EXP_MAX = 2047;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        PACK  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_pack.sv
// Combinational packer of sign/exponent/mantissa into an IEEE word.
// An unnormalized mantissa at exponent 1 is emitted as a denormal.
module fp_pack
    import fp_pkg::*;
#(
    parameter int MW = MANT_W,
    parameter int EW = EXP_W
) (
    input  logic          sign,
    input  logic [EW-1:0] exp,
    input  logic [MW-1:0] mant,
    output logic [EW+MW-1:0] word
);

    logic          denorm;
    logic [EW-1:0] exp_out;

    assign denorm  = !mant[MW-1] && (exp == EW'(1));
    assign exp_out = denorm ? '0 : exp;
    assign word    = {sign, exp_out, mant[MW-2:0]};

endmodule

// File: rtl/fp_normalize.sv
// Post-adder normalizer: carry fixup, left-shift normalization
// one bit per cycle, then packing into an IEEE-754 word.
module fp_normalize
    import fp_pkg::*;
#(
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int EXP_W  = fp_pkg::EXP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic                    carry,
    input  logic [MANT_W-1:0]       mant,
    input  logic                    sign,
    input  logic [EXP_W-1:0]        exp,
    output logic [EXP_W+MANT_W-1:0] result,
    output logic                    done,
    output logic                    busy,
    output logic                    overflow,
    output logic                    zero
);

    localparam logic [EXP_W-1:0] E_ALL = '1;
    localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);

    state_t state, state_n;

    logic [MANT_W-1:0] m_q, m_n;
    logic [EXP_W-1:0]  e_q, e_n;
    logic              s_q, s_n;
    logic              c_q, c_n;
    logic              ovf_q, ovf_n;
    logic              zero_q, zero_n;

    logic [EXP_W-1:0]        e_inc, e_dec;
    logic [MANT_W-1:0]       m_shl;
    logic [EXP_W+MANT_W-1:0] word;

    assign e_inc = e_q + E_ONE;
    assign e_dec = e_q - E_ONE;
    assign m_shl = m_q << 1;
    assign busy  = (state != IDLE);

    fp_pack #(
        .MW (MANT_W),
        .EW (EXP_W)
    ) u_pack (
        .sign (s_q),
        .exp  (e_q),
        .mant (m_q),
        .word (word)
    );

    always_comb begin
        state_n = state;
        m_n     = m_q;
        e_n     = e_q;
        s_n     = s_q;
        c_n     = c_q;
        ovf_n   = ovf_q;
        zero_n  = zero_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    m_n     = mant;
                    e_n     = exp;
                    s_n     = sign;
                    c_n     = carry;
                    ovf_n   = 1'b0;
                    zero_n  = 1'b0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                state_n = PACK;
                if (e_q == E_ALL) begin
                    state_n = PACK;
                end else if (c_q) begin
                    m_n = {1'b1, m_q[MANT_W-1:1]};
                    e_n = e_inc;
                    if (e_inc == E_ALL) begin
                        m_n   = '0;
                        ovf_n = 1'b1;
                    end
                end else if (m_q == '0) begin
                    e_n    = '0;
                    zero_n = 1'b1;
                end else if (!m_q[MANT_W-1] && e_q > E_ONE) begin
                    // exp 0/1 cannot shift without dropping below 1
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                m_n = m_shl;
                e_n = e_dec;
                if (m_shl[MANT_W-1] || e_dec == E_ONE) begin
                    state_n = PACK;
                end
            end
            PACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m_q      <= '0;
            e_q      <= '0;
            s_q      <= 1'b0;
            c_q      <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                state  <= state_n;
                m_q    <= m_n;
                e_q    <= e_n;
                s_q    <= s_n;
                c_q    <= c_n;
                ovf_q  <= ovf_n;
                zero_q <= zero_n;
                if (state == PACK) begin
                    result   <= word;
                    done     <= 1'b1;
                    overflow <= ovf_q;
                    zero     <= zero_q;
                end
            end
        end
    end

endmodule
